// File: rtl/pwr_pkg.sv
// Shared types and constants for the power-enable sequencer.
package pwr_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STEP      = 3'd1,
    RAMP_UP   = 3'd2,
    DWELL     = 3'd3,
    RAMP_DOWN = 3'd4
  } pwr_state_t;

  localparam logic [1:0] MODE_STAIR = 2'd0;
  localparam logic [1:0] MODE_SWEEP = 2'd1;
  localparam logic [1:0] MODE_SOAK  = 2'd2;

  localparam int N_DUT_DEF    = 32;
  localparam int ECHO_LAT_DEF = 2;
endpackage

// File: rtl/pwr_en_seq_if.sv
// Control/status bundle between the experiment controller and pwr_en_seq.
interface pwr_en_seq_if import pwr_pkg::*; #(
  parameter int N_DUT   = N_DUT_DEF,
  parameter int DWELL_W = 32
);
  logic               start;
  logic               abort;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell_cycles;
  logic [N_DUT-1:0]   pwr_en_out;
  logic [N_DUT-1:0]   dummy_in;
  logic               busy;
  logic               done;
  logic [5:0]         step_idx;
  logic               mismatch;
  logic [N_DUT-1:0]   mismatch_mask;

  modport master (
    output start, abort, mode, dwell_cycles, dummy_in,
    input  pwr_en_out, busy, done, step_idx, mismatch, mismatch_mask
  );
  modport slave (
    input  start, abort, mode, dwell_cycles, dummy_in,
    output pwr_en_out, busy, done, step_idx, mismatch, mismatch_mask
  );
endinterface

// File: rtl/pwr_echo_chk.sv
// Delays the driven enable pattern by ECHO_LAT and compares it with the returned
// dummy bus; failures accumulate into sticky flags until clr.
module pwr_echo_chk import pwr_pkg::*; #(
  parameter int N_DUT    = N_DUT_DEF,
  parameter int ECHO_LAT = ECHO_LAT_DEF
) (
  input  logic             clk100m,
  input  logic             rstn,
  input  logic             clr,
  input  logic             vld,
  input  logic [N_DUT-1:0] exp,
  input  logic [N_DUT-1:0] obs,
  output logic             mismatch,
  output logic [N_DUT-1:0] mismatch_mask
);
  logic [ECHO_LAT:1]            vld_pipe;
  logic [ECHO_LAT:1][N_DUT-1:0] exp_pipe;
  logic [N_DUT-1:0]             err;

  assign err = vld_pipe[ECHO_LAT] ? (obs ^ exp_pipe[ECHO_LAT]) : '0;

  // clr drops history but still records a failure seen in the same cycle
  always_ff @(posedge clk100m) begin
    if (!rstn) begin
      vld_pipe      <= '0;
      exp_pipe      <= '0;
      mismatch      <= 1'b0;
      mismatch_mask <= '0;
    end else begin
      vld_pipe[1] <= vld;
      exp_pipe[1] <= exp;
      for (int i = 2; i <= ECHO_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
      mismatch      <= (clr ? 1'b0 : mismatch) | (|err);
      mismatch_mask <= (clr ? '0 : mismatch_mask) | err;
    end
  end
endmodule

// File: rtl/pwr_en_seq.sv
// Power-stepping experiment sequencer: staircase, one-hot sweep and soak with
// soft ramp-down, plus echo checking of the DUT array's dummy outputs.
module pwr_en_seq import pwr_pkg::*; #(
  parameter int N_DUT    = N_DUT_DEF,
  parameter int DWELL_W  = 32,
  parameter int STEP_GAP = 16,
  parameter int ECHO_LAT = ECHO_LAT_DEF
) (
  input logic         clk100m,
  input logic         rstn,
  pwr_en_seq_if.slave bus
);
  localparam int GAP_W = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RLD   = GAP_W'(STEP_GAP - 1);
  localparam logic [5:0]       LAST_STEP = 6'(N_DUT - 1);
  localparam logic [N_DUT-1:0] ALL_ON    = '1;

  pwr_state_t         state_q, state_n;
  logic [N_DUT-1:0]   pat_q, pat_n;
  logic [DWELL_W-1:0] cnt_q, cnt_n, dld_q, dld_n, dmin1;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic [5:0]         step_q, step_n;
  logic [1:0]         mode_q, mode_n, mode_norm;
  logic               busy_q, busy_n, done_q, done_n;
  logic               to_down, to_fin, clr;
  logic               chk_mm;
  logic [N_DUT-1:0]   chk_mask;

  always_ff @(posedge clk100m) begin
    if (!rstn) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      dld_q   <= '0;
      gap_q   <= '0;
      step_q  <= '0;
      mode_q  <= MODE_STAIR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      pat_q   <= pat_n;
      cnt_q   <= cnt_n;
      dld_q   <= dld_n;
      gap_q   <= gap_n;
      step_q  <= step_n;
      mode_q  <= mode_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    pat_n   = pat_q;
    cnt_n   = cnt_q;
    dld_n   = dld_q;
    gap_n   = gap_q;
    step_n  = step_q;
    mode_n  = mode_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    to_down = 1'b0;
    to_fin  = 1'b0;
    clr     = 1'b0;
    dmin1   = (bus.dwell_cycles == '0) ? '0 : bus.dwell_cycles - 1'b1;
    case (bus.mode)
      MODE_SWEEP: mode_norm = MODE_SWEEP;
      MODE_SOAK:  mode_norm = MODE_SOAK;
      default:    mode_norm = MODE_STAIR;
    endcase

    case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        if (bus.start) begin
          clr    = 1'b1;
          mode_n = mode_norm;
          dld_n  = dmin1;
          busy_n = 1'b1;
          pat_n  = N_DUT'(1);
          step_n = '0;
          if (mode_norm == MODE_SOAK) begin
            state_n = RAMP_UP;
            gap_n   = GAP_RLD;
          end else begin
            state_n = STEP;
            cnt_n   = dmin1;
          end
        end
      end
      STEP: begin
        if (bus.abort) begin
          if (mode_q == MODE_SWEEP) to_fin = 1'b1;
          else                      to_down = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_n = cnt_q - 1'b1;
        end else if (step_q == LAST_STEP) begin
          if (mode_q == MODE_SWEEP) to_fin = 1'b1;
          else                      to_down = 1'b1;
        end else begin
          step_n = step_q + 6'd1;
          pat_n  = (mode_q == MODE_SWEEP) ? (pat_q << 1) : ((pat_q << 1) | N_DUT'(1));
          cnt_n  = dld_q;
        end
      end
      RAMP_UP: begin
        if (bus.abort) begin
          to_down = 1'b1;
        end else if (gap_q != '0) begin
          gap_n = gap_q - 1'b1;
        end else begin
          pat_n = (pat_q << 1) | N_DUT'(1);
          if (pat_n == ALL_ON) begin
            state_n = DWELL;
            cnt_n   = dld_q;
          end else begin
            gap_n = GAP_RLD;
          end
        end
      end
      DWELL: begin
        if (bus.abort || cnt_q == '0) to_down = 1'b1;
        else                          cnt_n = cnt_q - 1'b1;
      end
      RAMP_DOWN: begin
        // already heading to zero, so abort has nothing left to shorten
        if (gap_q == '0) to_down = 1'b1;
        else             gap_n = gap_q - 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // patterns in staircase/soak are always thermometer codes, so dropping the
    // top set bit is a right shift
    if (to_down) begin
      state_n = RAMP_DOWN;
      pat_n   = pat_q >> 1;
      gap_n   = GAP_RLD;
      if (pat_n == '0) to_fin = 1'b1;
    end
    if (to_fin) begin
      state_n = IDLE;
      pat_n   = '0;
      busy_n  = 1'b0;
      done_n  = 1'b1;
      step_n  = '0;
    end
  end

  pwr_echo_chk #(.N_DUT(N_DUT), .ECHO_LAT(ECHO_LAT)) u_echo (
    .clk100m       (clk100m),
    .rstn          (rstn),
    .clr           (clr),
    .vld           (busy_q | done_q),
    .exp           (pat_q),
    .obs           (bus.dummy_in),
    .mismatch      (chk_mm),
    .mismatch_mask (chk_mask)
  );

  assign bus.pwr_en_out    = pat_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.step_idx      = step_q;
  assign bus.mismatch      = chk_mm;
  assign bus.mismatch_mask = chk_mask;
endmodule

// File: tb/tb_pwr_en_seq.sv
// Bench for pwr_en_seq: directed vector tables, hand-written corner sequences and
// randomized experiments against a trace-building reference model.
module tb_pwr_en_seq;
  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int LAT = 2;

  logic clk100m = 1'b0;
  logic rstn    = 1'b0;
  always #5 clk100m = ~clk100m;

  pwr_en_seq_if #(.N_DUT(N), .DWELL_W(32)) bus ();

  pwr_en_seq #(.N_DUT(N), .DWELL_W(32), .STEP_GAP(GAP), .ECHO_LAT(LAT)) dut (
    .clk100m (clk100m),
    .rstn    (rstn),
    .bus     (bus.slave)
  );

  // DUT-array stand-in: two-register echo with optional stuck lanes
  logic [N-1:0] d1, d2, stuck0, stuck1;
  always @(posedge clk100m) begin
    d1 <= bus.pwr_en_out;
    d2 <= d1;
  end
  assign bus.dummy_in = (d2 & ~stuck0) | stuck1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk100m);
    #1;
  endtask

  // expected per-cycle trace, index 0 = first cycle after the start edge
  int tp[$];
  int ts[$];
  bit trd[$];

  task automatic push(int p, int s, bit rd);
    tp.push_back(p);
    ts.push_back(s);
    trd.push_back(rd);
  endtask

  function automatic int clrmsb(int p);
    for (int b = N - 1; b >= 0; b--) if (p[b]) return p & ~(1 << b);
    return p;
  endfunction

  task automatic push_down(int p0, int sidx);
    int p;
    p = p0;
    while (p != 0) begin
      p = clrmsb(p);
      if (p == 0) break;
      repeat (GAP) push(p, sidx, 1'b1);
    end
    push(0, -1, 1'b1);
  endtask

  task automatic build(int m, int d);
    tp.delete(); ts.delete(); trd.delete();
    if (m == 1) begin
      for (int k = 0; k < N; k++) repeat (d) push(1 << k, k, 1'b0);
      push(0, -1, 1'b1);
    end else if (m == 2) begin
      for (int k = 1; k <= N; k++) repeat ((k < N) ? GAP : d) push((1 << k) - 1, 0, 1'b0);
      push_down((1 << N) - 1, 0);
    end else begin
      for (int k = 1; k <= N; k++) repeat (d) push((1 << k) - 1, k - 1, 1'b0);
      push_down((1 << N) - 1, -1);
    end
  endtask

  task automatic run_exp(string nm, int md, int dw, int ab_in, logic [N-1:0] s0, logic [N-1:0] s1);
    int m, ab;
    logic [N-1:0] pv, mexp;
    m  = (md == 3) ? 0 : md;
    ab = ab_in;
    build(m, (dw == 0) ? 1 : dw);
    if (ab >= 0) begin
      ab = ab % tp.size();
      while (ab > 0 && trd[ab]) ab--;
      if (trd[ab]) ab = -1;
    end
    stuck0 = s0;
    stuck1 = s1;
    repeat (LAT + 2) tick();
    bus.mode = 2'(md);
    bus.dwell_cycles = 32'(dw);
    bus.start = 1'b1;
    tick();
    chk({nm, "_clr"}, bus.mismatch, 0);
    for (int i = 0; i < tp.size(); i++) begin
      if (i > 0) tick();
      chk($sformatf("%s_c%0d_pat", nm, i + 1), bus.pwr_en_out, tp[i]);
      chk($sformatf("%s_c%0d_done", nm, i + 1), bus.done, (i == tp.size() - 1));
      chk($sformatf("%s_c%0d_busy", nm, i + 1), bus.busy, (i != tp.size() - 1));
      if (ts[i] >= 0) chk($sformatf("%s_c%0d_step", nm, i + 1), bus.step_idx, ts[i]);
      bus.abort = (i == ab);
      if (i == ab) begin
        while (tp.size() > i + 1) begin tp.pop_back(); ts.pop_back(); trd.pop_back(); end
        if (m == 1) push(0, -1, 1'b1);
        else        push_down(tp[i], (m == 2) ? 0 : -1);
      end
      bus.start = (i < tp.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    tick();
    chk({nm, "_idle_busy"}, bus.busy, 0);
    chk({nm, "_idle_done"}, bus.done, 0);
    repeat (LAT) tick();
    mexp = '0;
    foreach (tp[i]) begin
      pv = N'(tp[i]);
      mexp |= (pv & s0) | (~pv & s1);
    end
    chk({nm, "_mm"}, bus.mismatch, (mexp != '0));
    chk({nm, "_mmask"}, bus.mismatch_mask, mexp);
  endtask

  typedef struct {
    int md; int dw; int lo; int hi; int pat; bit dn;
  } row_t;

  initial begin
    row_t tbl[$];
    int cyc;
    logic [N-1:0] s0, s1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'd0; bus.dwell_cycles = '0;
    stuck0 = '0; stuck1 = '0;
    cyc = 0;

    // staircase D=3, sweep D=2, soak D=5
    tbl.push_back('{0, 3,  1,  3, 4'h1, 1'b0});
    tbl.push_back('{0, 3,  4,  6, 4'h3, 1'b0});
    tbl.push_back('{0, 3,  7,  9, 4'h7, 1'b0});
    tbl.push_back('{0, 3, 10, 12, 4'hF, 1'b0});
    tbl.push_back('{0, 3, 13, 14, 4'h7, 1'b0});
    tbl.push_back('{0, 3, 15, 16, 4'h3, 1'b0});
    tbl.push_back('{0, 3, 17, 18, 4'h1, 1'b0});
    tbl.push_back('{0, 3, 19, 19, 4'h0, 1'b1});
    tbl.push_back('{1, 2,  1,  2, 4'h1, 1'b0});
    tbl.push_back('{1, 2,  3,  4, 4'h2, 1'b0});
    tbl.push_back('{1, 2,  5,  6, 4'h4, 1'b0});
    tbl.push_back('{1, 2,  7,  8, 4'h8, 1'b0});
    tbl.push_back('{1, 2,  9,  9, 4'h0, 1'b1});
    tbl.push_back('{2, 5,  1,  2, 4'h1, 1'b0});
    tbl.push_back('{2, 5,  3,  4, 4'h3, 1'b0});
    tbl.push_back('{2, 5,  5,  6, 4'h7, 1'b0});
    tbl.push_back('{2, 5,  7, 11, 4'hF, 1'b0});
    tbl.push_back('{2, 5, 12, 13, 4'h7, 1'b0});
    tbl.push_back('{2, 5, 14, 15, 4'h3, 1'b0});
    tbl.push_back('{2, 5, 16, 17, 4'h1, 1'b0});
    tbl.push_back('{2, 5, 18, 18, 4'h0, 1'b1});

    repeat (3) tick();
    chk("rst_pat",   bus.pwr_en_out, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_step",  bus.step_idx, 0);
    chk("rst_mm",    bus.mismatch, 0);
    chk("rst_mmask", bus.mismatch_mask, 0);
    rstn = 1'b1;
    tick();

    foreach (tbl[r]) begin
      if (tbl[r].lo == 1) begin
        repeat (LAT + 2) tick();
        bus.mode = 2'(tbl[r].md);
        bus.dwell_cycles = 32'(tbl[r].dw);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
      end
      for (int c = tbl[r].lo; c <= tbl[r].hi; c++) begin
        while (cyc < c) begin tick(); cyc++; end
        chk($sformatf("tbl%0d_c%0d_pat", r, c), bus.pwr_en_out, tbl[r].pat);
        chk($sformatf("tbl%0d_c%0d_done", r, c), bus.done, tbl[r].dn);
        chk($sformatf("tbl%0d_c%0d_busy", r, c), bus.busy, !tbl[r].dn);
      end
      if (tbl[r].dn) begin
        repeat (LAT + 1) tick();
        chk($sformatf("tbl%0d_mm", r), bus.mismatch, 0);
      end
    end

    // abort on the first staircase step, then start+abort together in IDLE
    repeat (LAT + 2) tick();
    bus.mode = 2'd0; bus.dwell_cycles = 32'd10; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    repeat (4) tick();
    chk("ab_c5_pat", bus.pwr_en_out, 4'h1);
    bus.abort = 1'b1;
    tick(); bus.abort = 1'b0;
    chk("ab_c6_pat",  bus.pwr_en_out, 0);
    chk("ab_c6_done", bus.done, 1);
    chk("ab_c6_busy", bus.busy, 0);
    tick();
    bus.mode = 2'd1; bus.dwell_cycles = 32'd1; bus.start = 1'b1; bus.abort = 1'b1;
    tick(); bus.start = 1'b0; bus.abort = 1'b0;
    chk("ab_c8_pat",  bus.pwr_en_out, 4'h1);
    chk("ab_c8_busy", bus.busy, 1);
    bus.abort = 1'b1;
    tick(); bus.abort = 1'b0;
    chk("ab_sweep_pat",  bus.pwr_en_out, 0);
    chk("ab_sweep_done", bus.done, 1);

    // stuck-at-0 lane 2 during soak, then a clean run clears the flags
    run_exp("stuck2", 2, 3, -1, 4'h4, 4'h0);
    run_exp("clean",  0, 1, -1, 4'h0, 4'h0);
    run_exp("abort4", 0, 10, 4, 4'h0, 4'h0);
    run_exp("dw0_sweep", 1, 0, -1, 4'h0, 4'h0);
    run_exp("alias3", 3, 2, -1, 4'h0, 4'h8);

    // longest legal dwell holds without wrapping
    repeat (LAT + 2) tick();
    bus.mode = 2'd1; bus.dwell_cycles = 32'hFFFF_FFFF; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    repeat (40) tick();
    chk("maxdw_pat",  bus.pwr_en_out, 4'h1);
    chk("maxdw_step", bus.step_idx, 0);
    bus.abort = 1'b1;
    tick(); bus.abort = 1'b0;
    chk("maxdw_done", bus.done, 1);

    // reset during soak dwell; start while busy is ignored
    repeat (LAT + 2) tick();
    bus.mode = 2'd2; bus.dwell_cycles = 32'd20; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    repeat (7) tick();
    chk("rstmid_c8_pat", bus.pwr_en_out, 4'hF);
    bus.mode = 2'd1; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    chk("busy_start_pat",  bus.pwr_en_out, 4'hF);
    chk("busy_start_busy", bus.busy, 1);
    rstn = 1'b0;
    tick();
    chk("rstmid_pat",  bus.pwr_en_out, 0);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_done", bus.done, 0);
    rstn = 1'b1;
    tick();
    chk("rstmid_done2", bus.done, 0);
    chk("rstmid_busy2", bus.busy, 0);

    for (int t = 0; t < 30; t++) begin
      s0 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      s1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      run_exp($sformatf("rnd%0d", t), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1, s0, s1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pwr_en_seq.md
Name: pwr_en_seq

Overview:
- Drives the 32-bit power-enable vector of the DUT array and reads back the DUT array's registered dummy outputs.
- Runs software-triggered power-stepping experiments in one of three modes: staircase, one-hot sweep, or all-on soak.
- Soft ramp-down limits current transients when an experiment ends or is aborted.
- An echo checker confirms that every enable bit returns on the dummy bus after the fixed pipeline latency.

Parameters:
- N_DUT, 32, number of enable/dummy lanes (2..32).
- DWELL_W, 32, width of the dwell-cycle count.
- STEP_GAP, 16, cycles between single-bit changes during ramp-up/ramp-down (>=1).
- ECHO_LAT, 2, cycles from pwr_en_out to the matching dummy_in.

Ports:
- clk100m  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  begin experiment; accepted only when busy=0.
- abort  in  1  stop the current experiment; ignored when busy=0.
- mode  in  2  0=staircase, 1=one-hot sweep, 2=all-on soak, 3=staircase (alias).
- dwell_cycles  in  DWELL_W  hold time per step.
- pwr_en_out  out  N_DUT  enable vector to the DUT array (registered).
- dummy_in  in  N_DUT  registered echo from the DUT array.
- busy  out  1  experiment active.
- done  out  1  one-cycle completion pulse.
- step_idx  out  6  current step number (0-based).
- mismatch  out  1  sticky echo error flag.
- mismatch_mask  out  N_DUT  sticky OR of the failing lanes.

Behaviour:
- Reset (rstn=0 at a clock edge): all outputs go to 0, state goes to IDLE, and the echo pipeline is cleared.
- State machine: IDLE, STEP, RAMP_UP, DWELL, RAMP_DOWN.
- Start acceptance (IDLE, start=1):
  - mode and dwell_cycles are latched; D = max(dwell_cycles, 1).
  - mismatch and mismatch_mask are cleared.
  - busy goes high on the next cycle.
  - start=1 while busy is ignored.
- Mode 0 (staircase):
  - For k = 1..N_DUT, in STEP: pwr_en_out = (1<<k)-1, held D cycles; step_idx = k-1.
  - The first pattern appears the cycle after start.
  - After the last step, go to RAMP_DOWN.
- Mode 1 (sweep):
  - For k = 0..N_DUT-1, in STEP: pwr_en_out = 1<<k for D cycles; step_idx = k.
  - After the last step, pwr_en_out = 0 with no ramp.
- Mode 2 (soak):
  - RAMP_UP: set bit 0 the cycle after start, then set the next-higher bit every STEP_GAP cycles until all N_DUT bits are set.
  - DWELL: hold all-ones for D cycles, then go to RAMP_DOWN.
  - step_idx = 0 throughout.
- RAMP_DOWN:
  - On entry, clear the highest set bit.
  - Clear the next highest bit every STEP_GAP cycles.
- Completion: the cycle in which pwr_en_out becomes 0 has done=1 and busy=0, and the state returns to IDLE.
- Abort while busy:
  - Mode 1: pwr_en_out = 0 and completion fire on the next cycle.
  - Modes 0/2: enter RAMP_DOWN next cycle from the current pattern.
  - If the pattern is already 0, complete next cycle.
- Simultaneous start and abort in IDLE: start is accepted.
- Echo check:
  - An ECHO_LAT-deep pipeline carries pwr_en_out plus a valid bit (valid = busy or done of that cycle).
  - When the delayed valid=1 and dummy_in != delayed pattern, set mismatch=1 and OR (dummy_in ^ expected) into mismatch_mask.
  - The check continues for ECHO_LAT cycles after done, so the final zero pattern is checked.
  - A new start does not flush the pipeline, but clears the sticky flags in the accept cycle.
- Dwell counter: DWELL_W bits, counts down from D-1 to 0, no wrap-around; dwell_cycles = 2^DWELL_W-1 is valid.
- Ramp counter: counts STEP_GAP-1 down to 0.
- Reset mid-operation: pwr_en_out = 0 at the next edge; no done pulse.

Decomposition:
- Shared package pwr_pkg holds:
  - the state enum;
  - the MODE_STAIR/MODE_SWEEP/MODE_SOAK encodings;
  - the default constants N_DUT=32 and ECHO_LAT=2.
- One sub-module, pwr_echo_chk: the delay pipeline, comparator and sticky flags.
  - Parameters: N_DUT, ECHO_LAT.
  - Ports: clk100m, rstn, clr, vld, exp, obs, mismatch, mismatch_mask.

Test Plan:
1. N_DUT=4, STEP_GAP=2, mode 0, D=3, start at cycle 0 -> pwr_en_out follows this sequence:
   - 0x1 on cycles 1-3, 0x3 on 4-6, 0x7 on 7-9, 0xF on 10-12;
   - 0x7 on 13-14, 0x3 on 15-16, 0x1 on 17-18;
   - 0x0 with done=1 and busy=0 on cycle 19.
2. N_DUT=4, mode 1, D=2, dummy_in = pwr_en_out delayed 2 cycles -> out 0x1, 0x2, 0x4, 0x8 for 2 cycles each; done on cycle 9; mismatch stays 0.
3. N_DUT=4, STEP_GAP=2, mode 2, D=5 -> 0x1@1, 0x3@3, 0x7@5, 0xF@7-11, 0x7@12, 0x3@14, 0x1@16, 0x0 and done@18.
4. Mode 0, D=10, abort at cycle 5 (pattern 0x1) -> cycle 6 out 0x0 with done=1; a second start in cycle 7 is accepted.
5. Loopback with dummy_in bit 2 stuck at 0, mode 2 -> mismatch=1 and mismatch_mask=0x4; the next accepted start clears both.
6. Assert rstn=0 during DWELL with out 0xF -> next edge gives out 0, busy 0, no done pulse; start=1 while busy is ignored (pattern unchanged).
